// File: rtl/pa_seq_pkg.sv
// Shared definitions for the PA power sequencer: register map, CTRL fields
// and state codes (state codes are also the STATUS[2:0] encoding).
package pa_seq_pkg;

  localparam logic [1:0] PA_SEQ_CTRL  = 2'd0;
  localparam logic [1:0] PA_SEQ_TSET  = 2'd1;
  localparam logic [1:0] PA_SEQ_THOLD = 2'd2;
  localparam logic [1:0] PA_SEQ_STAT  = 2'd3;

  localparam int CTRL_START = 0;
  localparam int CTRL_STOP  = 1;
  localparam int CTRL_MODE  = 2;

  localparam int STAT_ERR  = 3;
  localparam int STAT_DONE = 4;

  typedef enum logic [2:0] {
    ST_OFF  = 3'd0,
    ST_WAKE = 3'd1,
    ST_ON   = 3'd2,
    ST_COOL = 3'd3
  } pa_state_e;

endpackage

// File: rtl/pa_seq_if.sv
// CPU register-bus bundle for the PA sequencer: single-cycle valid,
// one-cycle ready acknowledge with registered read data.
interface pa_seq_if #(
  parameter int DATA_W = 32
);
  logic              valid;
  logic [1:0]        address;
  logic [DATA_W-1:0] wdata;
  logic              wstrb;
  logic [DATA_W-1:0] rdata;
  logic              ready;

  modport master (output valid, address, wdata, wstrb, input rdata, ready);
  modport slave  (input valid, address, wdata, wstrb, output rdata, ready);
endinterface

// File: rtl/pa_seq_timer.sv
// Loadable down-counter for settle/hold intervals; holds at zero instead of
// wrapping so an idle timer never produces a spurious terminal count.
module pa_seq_timer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             dec,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/pa_seq.sv
// PA power-up/power-down sequencer with CPU register file. Drives pa_pd and
// pa_mode through timed states so the PA settles before RF and ramps down cleanly.
//
//   state | meaning
//   OFF   | PA powered down, waiting for START or tx_req
//   WAKE  | PA powered, RF off, settling for max(T_SETTLE,1) cycles
//   ON    | RF enabled at latched MODE until T_HOLD, tx_done or STOP
//   COOL  | RF off, PA still powered for max(T_SETTLE,1) cycles
module pa_seq
  import pa_seq_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic       clk,
  input  logic       rst,
  pa_seq_if.slave    bus,
  input  logic       tx_req,
  input  logic       tx_done,
  output logic       pa_pd,
  output logic [1:0] pa_mode,
  output logic       pa_on,
  output logic       busy
);

  function automatic logic [CNT_W-1:0] minus1(input logic [CNT_W-1:0] v);
    return (v == '0) ? '0 : v - 1'b1;
  endfunction

  pa_state_e         state, state_next;
  logic [1:0]        mode_reg, mode_w;
  logic [CNT_W-1:0]  t_settle, t_hold, tset_w, thold_w;
  logic              err, done;

  logic              wr, rd, wr_ctrl, cpu_start, cpu_stop, start_req, stat_rd;
  logic              seq_start, seq_done, err_set;
  logic              tmr_load, tmr_dec, tmr_zero;
  logic [CNT_W-1:0]  tmr_val;
  logic [DATA_W-1:0] rd_mux;
  logic [1:0]        start_mode;
  logic              unused_wdata;

  assign wr         = bus.valid & bus.wstrb;
  assign rd         = bus.valid & ~bus.wstrb;
  assign wr_ctrl    = wr && (bus.address == PA_SEQ_CTRL);
  assign cpu_stop   = wr_ctrl & bus.wdata[CTRL_STOP];
  assign cpu_start  = wr_ctrl & bus.wdata[CTRL_START] & ~bus.wdata[CTRL_STOP];
  assign start_req  = cpu_start | tx_req;
  assign stat_rd    = rd && (bus.address == PA_SEQ_STAT);
  assign err_set    = start_req && (state != ST_OFF);
  // A START write carries its own MODE, which is not yet in mode_reg.
  assign start_mode = wr_ctrl ? bus.wdata[CTRL_MODE +: 2] : mode_reg;
  assign unused_wdata = ^bus.wdata[DATA_W-1:CNT_W];

  pa_seq_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .dec      (tmr_dec),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_OFF;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    tmr_load   = 1'b0;
    tmr_dec    = 1'b0;
    tmr_val    = '0;
    seq_start  = 1'b0;
    seq_done   = 1'b0;
    case (state)
      ST_OFF: begin
        if (start_req) begin
          state_next = ST_WAKE;
          tmr_load   = 1'b1;
          tmr_val    = minus1(t_settle);
          seq_start  = 1'b1;
        end
      end
      ST_WAKE: begin
        if (cpu_stop) begin
          state_next = ST_COOL;
          tmr_load   = 1'b1;
          tmr_val    = minus1(tset_w);
        end else if (tmr_zero) begin
          state_next = ST_ON;
          tmr_load   = 1'b1;
          tmr_val    = minus1(thold_w);
        end else begin
          tmr_dec = 1'b1;
        end
      end
      ST_ON: begin
        // T_HOLD=0 means unlimited: only tx_done or STOP leave ON.
        if (cpu_stop || tx_done || ((thold_w != '0) && tmr_zero)) begin
          state_next = ST_COOL;
          tmr_load   = 1'b1;
          tmr_val    = minus1(tset_w);
        end else begin
          tmr_dec = 1'b1;
        end
      end
      ST_COOL: begin
        if (tmr_zero) begin
          state_next = ST_OFF;
          seq_done   = 1'b1;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      default: state_next = ST_OFF;
    endcase
  end

  always_comb begin
    rd_mux = '0;
    case (bus.address)
      PA_SEQ_CTRL:  rd_mux[CTRL_MODE +: 2] = mode_reg;
      PA_SEQ_TSET:  rd_mux[CNT_W-1:0]      = t_settle;
      PA_SEQ_THOLD: rd_mux[CNT_W-1:0]      = t_hold;
      default: begin
        rd_mux[2:0]       = state;
        rd_mux[STAT_ERR]  = err;
        rd_mux[STAT_DONE] = done;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_reg  <= '0;
      t_settle  <= CNT_W'(1);
      t_hold    <= '0;
      mode_w    <= '0;
      tset_w    <= '0;
      thold_w   <= '0;
      err       <= 1'b0;
      done      <= 1'b0;
      bus.ready <= 1'b0;
      bus.rdata <= '0;
    end else begin
      if (wr_ctrl) mode_reg <= bus.wdata[CTRL_MODE +: 2];
      if (wr && (bus.address == PA_SEQ_TSET))  t_settle <= bus.wdata[CNT_W-1:0];
      if (wr && (bus.address == PA_SEQ_THOLD)) t_hold   <= bus.wdata[CNT_W-1:0];
      if (seq_start) begin
        mode_w  <= start_mode;
        tset_w  <= t_settle;
        thold_w <= t_hold;
      end
      // Set beats clear-on-read so an event during the read is never lost.
      err       <= err_set  | (err  & ~stat_rd);
      done      <= seq_done | (done & ~stat_rd);
      bus.ready <= bus.valid;
      bus.rdata <= rd ? rd_mux : '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pa_pd   <= 1'b1;
      pa_mode <= 2'b00;
      pa_on   <= 1'b0;
      busy    <= 1'b0;
    end else begin
      pa_pd   <= (state_next == ST_OFF);
      pa_mode <= (state_next == ST_ON) ? mode_w : 2'b00;
      pa_on   <= (state_next == ST_ON);
      busy    <= (state_next != ST_OFF);
    end
  end

endmodule
